// File: rtl/capture_replay_buffer.sv
// Captures one burst of ADC samples into block RAM, then replays it a fixed number
// of times as contiguous valid runs separated by a programmable idle gap.
module capture_replay_buffer #(
   parameter int SAMPLE_DATA_WIDTH = 8,
   parameter int CAPTURE_LENGTH    = 1000,
   parameter int REPLAY_PASSES     = 4,
   parameter int INTER_PASS_GAP    = 1,
   localparam int PW = (REPLAY_PASSES > 1) ? $clog2(REPLAY_PASSES) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         adc_valid,
   input  logic [SAMPLE_DATA_WIDTH-1:0] adc_data,
   output logic                         axiov,
   output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
   output logic [PW-1:0]                pass_index,
   output logic                         busy,
   output logic                         done
);

   localparam int AW = $clog2(CAPTURE_LENGTH);
   localparam int GW = (INTER_PASS_GAP > 1) ? $clog2(INTER_PASS_GAP) : 1;

   localparam logic [AW-1:0] LAST_ADDR = AW'(CAPTURE_LENGTH - 1);
   localparam logic [PW-1:0] LAST_PASS = PW'(REPLAY_PASSES - 1);
   localparam logic [GW-1:0] LAST_GAP  = GW'((INTER_PASS_GAP > 0) ? INTER_PASS_GAP - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      REPLAY,
      GAP,
      DRAIN,
      DONE
   } state_t;

   state_t                 state, state_n;
   logic [AW-1:0]          addr, addr_n;
   logic [PW-1:0]          pass_cnt, pass_n;
   logic [GW-1:0]          gap_cnt, gap_n;
   logic                   drain_cnt, drain_n;
   logic                   wr_en, rd_en;

   logic [SAMPLE_DATA_WIDTH-1:0] mem [CAPTURE_LENGTH];
   logic [SAMPLE_DATA_WIDTH-1:0] ram_q;
   logic                         rd_valid;
   logic [PW-1:0]                rd_pass;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         pass_cnt  <= '0;
         gap_cnt   <= '0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         pass_cnt  <= pass_n;
         gap_cnt   <= gap_n;
         drain_cnt <= drain_n;
      end
   end

   // One shared address counter: capture writes and replay reads never coexist.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      pass_n  = pass_cnt;
      gap_n   = gap_cnt;
      drain_n = drain_cnt;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = CAPTURE;
               addr_n  = '0;
               pass_n  = '0;
            end
         end
         CAPTURE: begin
            if (adc_valid) begin
               wr_en = 1'b1;
               if (addr == LAST_ADDR) begin
                  state_n = REPLAY;
                  addr_n  = '0;
                  pass_n  = '0;
               end else begin
                  addr_n = addr + 1'b1;
               end
            end
         end
         REPLAY: begin
            rd_en = 1'b1;
            if (addr == LAST_ADDR) begin
               addr_n = '0;
               if (pass_cnt == LAST_PASS) begin
                  state_n = DRAIN;
                  drain_n = 1'b0;
               end else begin
                  pass_n = pass_cnt + 1'b1;
                  if (INTER_PASS_GAP != 0) begin
                     state_n = GAP;
                     gap_n   = '0;
                  end
               end
            end else begin
               addr_n = addr + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == LAST_GAP) begin
               state_n = REPLAY;
               gap_n   = '0;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               state_n = DONE;
               drain_n = 1'b0;
            end else begin
               drain_n = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= adc_data;
      if (rd_en) ram_q <= mem[addr];
   end

   // Valid and pass number travel alongside the two-stage RAM read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid   <= 1'b0;
         rd_pass    <= '0;
         axiov      <= 1'b0;
         axiod      <= '0;
         pass_index <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_pass  <= pass_cnt;
         axiov    <= rd_valid;
         if (rd_valid) begin
            axiod      <= ram_q;
            pass_index <= rd_pass;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_capture_replay_buffer.sv
// Scoreboard bench for capture_replay_buffer: per-cycle expected outputs are queued
// when the last capture sample is driven and checked on every falling edge.
module tb_capture_replay_buffer;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic [1:0] p;
      logic       dn;
      logic       bz;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start_a, adc_valid_a, axiov_a, busy_a, done_a;
   logic [7:0] adc_data_a, axiod_a;
   logic [1:0] pass_index_a;
   logic       start_b, adc_valid_b, axiov_b, busy_b, done_b;
   logic [7:0] adc_data_b, axiod_b;
   logic [1:0] pass_index_b;

   exp_t       sb_a [$];
   exp_t       sb_b [$];
   exp_t       cur_a, cur_b;
   logic [7:0] hold_d [2];
   logic [1:0] hold_p [2];
   int         total = 0;
   int         bad   = 0;

   capture_replay_buffer #(
      .SAMPLE_DATA_WIDTH(8), .CAPTURE_LENGTH(8), .REPLAY_PASSES(3), .INTER_PASS_GAP(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start_a), .adc_valid(adc_valid_a), .adc_data(adc_data_a),
      .axiov(axiov_a), .axiod(axiod_a), .pass_index(pass_index_a), .busy(busy_a), .done(done_a)
   );

   capture_replay_buffer #(
      .SAMPLE_DATA_WIDTH(8), .CAPTURE_LENGTH(8), .REPLAY_PASSES(3), .INTER_PASS_GAP(0)
   ) dut_nogap (
      .clk(clk), .rst(rst), .start(start_b), .adc_valid(adc_valid_b), .adc_data(adc_data_b),
      .axiov(axiov_b), .axiod(axiod_b), .pass_index(pass_index_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb_a.size() > 0) begin
         cur_a = sb_a.pop_front();
         total++;
         if ({axiov_a, axiod_a, pass_index_a, done_a, busy_a} !== cur_a) begin
            bad++;
            $display("FAIL stream_gap1 t=%0t got v=%0b d=%0d p=%0d done=%0b busy=%0b want v=%0b d=%0d p=%0d done=%0b busy=%0b",
                     $time, axiov_a, axiod_a, pass_index_a, done_a, busy_a,
                     cur_a.v, cur_a.d, cur_a.p, cur_a.dn, cur_a.bz);
         end
      end
   end

   always @(negedge clk) begin
      if (sb_b.size() > 0) begin
         cur_b = sb_b.pop_front();
         total++;
         if ({axiov_b, axiod_b, pass_index_b, done_b, busy_b} !== cur_b) begin
            bad++;
            $display("FAIL stream_gap0 t=%0t got v=%0b d=%0d p=%0d done=%0b busy=%0b want v=%0b d=%0d p=%0d done=%0b busy=%0b",
                     $time, axiov_b, axiod_b, pass_index_b, done_b, busy_b,
                     cur_b.v, cur_b.d, cur_b.p, cur_b.dn, cur_b.bz);
         end
      end
   end

   task automatic set_inputs(input bit which, input logic st, input logic av, input logic [7:0] ad);
      if (which) begin
         start_b = st; adc_valid_b = av; adc_data_b = ad;
      end else begin
         start_a = st; adc_valid_a = av; adc_data_a = ad;
      end
   endtask

   task automatic push_entry(input bit which, input exp_t e);
      if (which) sb_b.push_back(e);
      else sb_a.push_back(e);
   endtask

   // Expected outputs from the last-write cycle through the cycle after done.
   task automatic push_replay(input bit which, input logic [7:0] smp [8]);
      int gap;
      gap = which ? 0 : 1;
      repeat (3) push_entry(which, {1'b0, hold_d[which], hold_p[which], 1'b0, 1'b1});
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 8; i++) push_entry(which, {1'b1, smp[i], 2'(p), 1'b0, 1'b1});
         if (p < 2)
            for (int g = 0; g < gap; g++) push_entry(which, {1'b0, smp[7], 2'(p), 1'b0, 1'b1});
      end
      push_entry(which, {1'b0, smp[7], 2'd2, 1'b1, 1'b1});
      push_entry(which, {1'b0, smp[7], 2'd2, 1'b0, 1'b0});
      hold_d[which] = smp[7];
      hold_p[which] = 2'd2;
   endtask

   task automatic do_capture(input bit which, input logic [7:0] base, input bit alternate,
                             input bit skip_start, input bit poke);
      logic [7:0] smp [8];
      if (!skip_start) begin
         set_inputs(which, 1'b1, 1'b0, 8'h00);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 8; i++) smp[i] = base + 8'(i);
      for (int i = 0; i < 8; i++) begin
         set_inputs(which, poke && (i == 3), 1'b1, smp[i]);
         if (i == 7) push_replay(which, smp);
         @(posedge clk); #1;
         if (alternate && i < 7) begin
            set_inputs(which, 1'b0, 1'b0, 8'hFF);
            @(posedge clk); #1;
         end
      end
      set_inputs(which, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_empty(input bit which, output bit ok);
      int n;
      n = 0;
      while (((which ? sb_b.size() : sb_a.size()) != 0) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      ok = ((which ? sb_b.size() : sb_a.size()) == 0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      set_inputs(1, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({axiov_a, axiod_a, pass_index_a, done_a, busy_a} !== 13'd0) begin
         bad++;
         $display("FAIL reset_gap1 got %b want 0", {axiov_a, axiod_a, pass_index_a, done_a, busy_a});
      end
      total++;
      if ({axiov_b, axiod_b, pass_index_b, done_b, busy_b} !== 13'd0) begin
         bad++;
         $display("FAIL reset_gap0 got %b want 0", {axiov_b, axiod_b, pass_index_b, done_b, busy_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         hold_d[k] = 8'h00;
         hold_p[k] = 2'd0;
      end
   endtask

   task automatic test_basic;
      bit ok;
      set_inputs(0, 1'b1, 1'b0, 8'h00);
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      total++;
      if (busy_a !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start got %b want 1", busy_a);
      end
      @(posedge clk); #1;
      do_capture(0, 8'd0, 1'b0, 1'b1, 1'b0);
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL basic_timeout got pending=%0d want 0", sb_a.size());
      end
   endtask

   task automatic test_alternating;
      bit ok;
      do_capture(0, 8'd10, 1'b1, 1'b0, 1'b0);
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL alternating_timeout got pending=%0d want 0", sb_a.size());
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      do_capture(1, 8'd0, 1'b0, 1'b0, 1'b0);
      wait_empty(1, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL back_to_back_timeout got pending=%0d want 0", sb_b.size());
      end
   endtask

   // Cycle N is the last-write cycle; done lands on N+29 for this configuration.
   task automatic test_start_ignored;
      bit ok;
      do_capture(0, 8'd40, 1'b0, 1'b0, 1'b1);
      repeat (9) begin @(posedge clk); #1; end
      set_inputs(0, 1'b1, 1'b0, 8'h00);
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      repeat (18) begin @(posedge clk); #1; end
      set_inputs(0, 1'b1, 1'b0, 8'h00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      total++;
      if (busy_a !== 1'b1) begin
         bad++;
         $display("FAIL restart_after_done got busy=%b want 1", busy_a);
      end
      @(posedge clk); #1;
      do_capture(0, 8'd50, 1'b0, 1'b1, 1'b0);
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL start_ignored_timeout got pending=%0d want 0", sb_a.size());
      end
   endtask

   task automatic test_reset_abort;
      bit   ok;
      exp_t keep;
      do_capture(0, 8'd0, 1'b0, 1'b0, 1'b0);
      repeat (13) begin @(posedge clk); #1; end
      rst  = 1'b1;
      keep = sb_a[0];
      sb_a.delete();
      sb_a.push_back(keep);
      repeat (8) sb_a.push_back(13'd0);
      for (int k = 0; k < 2; k++) begin
         hold_d[k] = 8'h00;
         hold_p[k] = 2'd0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL abort_timeout got pending=%0d want 0", sb_a.size());
      end
      do_capture(0, 8'd20, 1'b0, 1'b0, 1'b0);
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL recapture_timeout got pending=%0d want 0", sb_a.size());
      end
   endtask

   task automatic test_adc_noise;
      bit ok;
      repeat (4) begin
         set_inputs(0, 1'b0, 1'b1, 8'hFF);
         @(posedge clk); #1;
      end
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      total++;
      if ({busy_a, axiov_a} !== 2'b00) begin
         bad++;
         $display("FAIL idle_noise got busy/axiov=%b want 00", {busy_a, axiov_a});
      end
      @(posedge clk); #1;
      do_capture(0, 8'd30, 1'b0, 1'b0, 1'b0);
      repeat (20) begin
         set_inputs(0, 1'b0, 1'b1, 8'hFF);
         @(posedge clk); #1;
      end
      set_inputs(0, 1'b0, 1'b0, 8'h00);
      wait_empty(0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL noise_timeout got pending=%0d want 0", sb_a.size());
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_alternating;
      test_back_to_back;
      test_start_ignored;
      test_reset_abort;
      test_adc_noise;
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
